// File: rtl/audio_rd_sched.sv
// Audio FIFO read scheduler: issues bursts of FIFO reads in the horizontal
// blanking interval after START_H, and tracks per-frame audio presence.
module audio_rd_sched #(
  parameter int START_H    = 1530,
  parameter int BURST_LEN  = 32,
  parameter int GAP_LEN    = 4,
  parameter int MAX_BURSTS = 8
) (
  input  logic        fifo_clk,
  input  logic        sys_rst,
  input  logic [11:0] hcnt,
  input  logic [11:0] vcnt,
  input  logic        vde,
  input  logic        aempty,
  input  logic [3:0]  a_left,
  output logic        rd_en,
  output logic        audio_on,
  output logic        underrun,
  output logic [3:0]  burst_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [11:0] START_H_C = 12'(START_H);
  localparam logic [5:0]  LAST_BEAT = 6'(BURST_LEN - 1);
  localparam logic [3:0]  LAST_GAP  = 4'(GAP_LEN - 1);
  localparam logic [3:0]  MAX_B     = 4'(MAX_BURSTS);

  logic [1:0] state;
  logic       init;
  logic       seen;
  logic       more;
  logic       frame_start_q;
  logic [5:0] beat_cnt;
  logic [3:0] gap_cnt;
  logic [3:0] a_left_q;

  logic frame_start;
  logic at_start;
  logic last_beat;
  logic last_gap;
  logic a_drop;
  logic can_continue;

  // Frame start is qualified so a stalled counter cannot reload audio_on twice.
  assign frame_start  = (vcnt == 12'd0) && (hcnt == 12'd0) && !frame_start_q;
  assign at_start     = (hcnt == START_H_C);
  assign last_beat    = (beat_cnt == LAST_BEAT);
  assign last_gap     = (gap_cnt == LAST_GAP);
  assign a_drop       = (a_left < a_left_q);
  assign can_continue = more && !aempty && (burst_cnt < MAX_B);

  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      rd_en         <= 1'b0;
      underrun      <= 1'b0;
      audio_on      <= 1'b0;
      burst_cnt     <= 4'd0;
      init          <= 1'b0;
      seen          <= 1'b0;
      more          <= 1'b0;
      frame_start_q <= 1'b0;
      beat_cnt      <= 6'd0;
      gap_cnt       <= 4'd0;
      a_left_q      <= 4'd0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every branch below
      // reads the pre-edge values, independent of statement order.
      a_left_q      <= a_left;
      frame_start_q <= (vcnt == 12'd0) && (hcnt == 12'd0);

      if (vde) init <= 1'b1;

      if (frame_start) begin
        audio_on <= seen;
        seen     <= !aempty;
      end else if (!aempty) begin
        seen <= 1'b1;
      end

      // NOTE: pulse outputs get a default here and are only raised by the
      // branches that want them, so they can never stick high.
      rd_en    <= 1'b0;
      underrun <= 1'b0;

      if (vde) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (init && !aempty) state <= ARMED;
          end
          ARMED: begin
            if (aempty) begin
              state <= IDLE;
            end else if (at_start) begin
              state     <= BURST;
              beat_cnt  <= 6'd0;
              burst_cnt <= 4'd0;
              more      <= 1'b0;
              rd_en     <= 1'b1;
            end
          end
          BURST: begin
            beat_cnt <= beat_cnt + 6'd1;
            underrun <= aempty;
            if (a_drop) more <= 1'b1;
            if (last_beat) begin
              state   <= GAP;
              gap_cnt <= 4'd0;
              if (burst_cnt != 4'hF) burst_cnt <= burst_cnt + 4'd1;
            end else begin
              rd_en <= !aempty;
            end
          end
          GAP: begin
            if (last_gap) begin
              if (can_continue) begin
                state    <= BURST;
                beat_cnt <= 6'd0;
                more     <= 1'b0;
                rd_en    <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Line start wins over any same-cycle increment.
      if (hcnt == 12'd0) burst_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_audio_rd_sched.sv
// Scoreboard bench for audio_rd_sched: stimulus queues expected read/underrun
// positions and frame/line results; a monitor process consumes them.
module tb_audio_rd_sched;

  localparam int H_TOTAL = 2000;
  localparam int V_TOTAL = 4;
  localparam int H_ACT   = 1280;

  logic        fifo_clk = 1'b0;
  logic        sys_rst;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        vde;
  logic        aempty;
  logic [3:0]  a_left;
  logic        rd_en;
  logic        audio_on;
  logic        underrun;
  logic [3:0]  burst_cnt;

  audio_rd_sched dut (
    .fifo_clk  (fifo_clk),
    .sys_rst   (sys_rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .vde       (vde),
    .aempty    (aempty),
    .a_left    (a_left),
    .rd_en     (rd_en),
    .audio_on  (audio_on),
    .underrun  (underrun),
    .burst_cnt (burst_cnt)
  );

  initial forever #5 fifo_clk = ~fifo_clk;

  int errors   = 0;
  int n_checks = 0;
  int rd_obs   = 0;
  int un_obs   = 0;

  int exp_rd[$];
  int exp_un[$];
  int exp_aon[$];
  int exp_bc[$];

  // Stimulus knobs
  logic rst_force = 1'b1;
  logic vde_en    = 1'b0;
  int   vde_pulse = -1;
  logic emp_in    = 1'b0;
  logic emp_out   = 1'b0;
  int   emp_lo    = 1;
  int   emp_hi    = 0;
  int   aleft_mode = 0;
  int   rst_lo    = 1;
  int   rst_hi    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (v=%0d h=%0d)", name, act, exp, vcnt, hcnt);
    end
  endtask

  task automatic apply_inputs();
    int h;
    h = int'(hcnt);
    sys_rst = rst_force || (vcnt == 12'd1 && h >= rst_lo && h <= rst_hi);
    vde     = (vde_en && vcnt != 12'd0 && h < H_ACT) || (vcnt == 12'd1 && h == vde_pulse);
    aempty  = (h >= emp_lo && h <= emp_hi) ? emp_in : emp_out;
    case (aleft_mode)
      1:       a_left = (h < 1541) ? 4'd8 : 4'd7;
      2:       a_left = (h < 1541) ? 4'd15 : 4'(14 - (h - 1541) / 36);
      default: a_left = 4'd5;
    endcase
  endtask

  task automatic step();
    @(posedge fifo_clk);
    #1;
    if (int'(hcnt) == H_TOTAL - 1) begin
      hcnt = 12'd0;
      vcnt = (int'(vcnt) == V_TOTAL - 1) ? 12'd0 : vcnt + 12'd1;
    end else begin
      hcnt = hcnt + 12'd1;
    end
    apply_inputs();
  endtask

  task automatic set_pos(input int v, input int h);
    @(posedge fifo_clk);
    #1;
    vcnt = 12'(v);
    hcnt = 12'(h);
    apply_inputs();
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    while (!(int'(vcnt) == v && int'(hcnt) == h)) begin
      step();
      n++;
      if (n > 20000) begin
        n_checks++;
        errors++;
        $display("FAIL run_to_timeout: target v=%0d h=%0d not reached", v, h);
        break;
      end
    end
  endtask

  task automatic clear_stim();
    vde_en     = 1'b1;
    vde_pulse  = -1;
    emp_in     = 1'b0;
    emp_out    = 1'b0;
    emp_lo     = 1;
    emp_hi     = 0;
    aleft_mode = 0;
    rst_lo     = 1;
    rst_hi     = 0;
  endtask

  task automatic do_reset();
    rst_force = 1'b1;
    set_pos(2, 100);
    step();
    step();
    @(negedge fifo_clk);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_burst_cnt", int'(burst_cnt), 0);
    check("rst_audio_on", int'(audio_on), 0);
    rst_force = 1'b0;
  endtask

  task automatic push_reads(input int v, input int lo, input int hi);
    for (int h = lo; h <= hi; h++) exp_rd.push_back(v * 4096 + h);
  endtask

  task automatic end_scenario(input string nm, input int base_rd, input int n_rd,
                              input int base_un, input int n_un);
    @(negedge fifo_clk);
    #1;
    check({nm, "_reads"}, rd_obs - base_rd, n_rd);
    check({nm, "_underruns"}, un_obs - base_un, n_un);
    check({nm, "_rd_pending"}, exp_rd.size(), 0);
    check({nm, "_un_pending"}, exp_un.size(), 0);
    check({nm, "_bc_pending"}, exp_bc.size(), 0);
    check({nm, "_aon_pending"}, exp_aon.size(), 0);
    exp_rd.delete();
    exp_un.delete();
    exp_bc.delete();
    exp_aon.delete();
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    int pos;
    forever begin
      @(negedge fifo_clk);
      pos = int'(vcnt) * 4096 + int'(hcnt);
      if (rd_en === 1'b1) begin
        rd_obs++;
        if (exp_rd.size() == 0) check("rd_unexpected", int'(rd_en), 0);
        else check("rd_pos", pos, exp_rd.pop_front());
      end
      if (underrun === 1'b1) begin
        un_obs++;
        if (exp_un.size() == 0) check("underrun_unexpected", int'(underrun), 0);
        else check("underrun_pos", pos, exp_un.pop_front());
      end
      if (vcnt == 12'd0 && hcnt == 12'd1 && exp_aon.size() != 0)
        check("audio_on", int'(audio_on), exp_aon.pop_front());
      if (int'(hcnt) == H_TOTAL - 1 && exp_bc.size() != 0)
        check("burst_cnt", int'(burst_cnt), exp_bc.pop_front());
    end
  end

  initial begin
    int b_rd;
    int b_un;
    hcnt = 12'd100;
    vcnt = 12'd2;
    clear_stim();
    vde_en = 1'b0;
    apply_inputs();

    // S1: vde never high, data present: no reads for a full frame.
    do_reset();
    clear_stim();
    vde_en = 1'b0;
    b_rd = rd_obs; b_un = un_obs;
    exp_aon.push_back(1);
    set_pos(0, 2);
    run_to(0, 1);
    end_scenario("s1_no_init", b_rd, 0, b_un, 0);

    // S2: single burst at hcnt 1531..1562.
    do_reset();
    clear_stim();
    b_rd = rd_obs; b_un = un_obs;
    push_reads(1, 1531, 1562);
    exp_bc.push_back(1);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s2_one_burst", b_rd, 32, b_un, 0);

    // S3: a_left drops during burst 1 -> two bursts with a 4-cycle gap.
    do_reset();
    clear_stim();
    aleft_mode = 1;
    b_rd = rd_obs; b_un = un_obs;
    push_reads(1, 1531, 1562);
    push_reads(1, 1567, 1598);
    exp_bc.push_back(2);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s3_two_bursts", b_rd, 64, b_un, 0);

    // S4: a_left drops in every burst -> capped at 8 bursts.
    do_reset();
    clear_stim();
    aleft_mode = 2;
    b_rd = rd_obs; b_un = un_obs;
    for (int k = 0; k < 8; k++) push_reads(1, 1531 + 36 * k, 1562 + 36 * k);
    exp_bc.push_back(8);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s4_max_bursts", b_rd, 256, b_un, 0);

    // S5: FIFO empty when granting beats 10-12 -> 3 lost slots.
    do_reset();
    clear_stim();
    emp_lo = 1539; emp_hi = 1541; emp_in = 1'b1;
    b_rd = rd_obs; b_un = un_obs;
    push_reads(1, 1531, 1539);
    push_reads(1, 1543, 1562);
    for (int h = 1540; h <= 1542; h++) exp_un.push_back(4096 + h);
    exp_bc.push_back(1);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s5_underrun", b_rd, 29, b_un, 3);

    // S6a: audio_on across frame boundaries, including set-wins-over-clear.
    do_reset();
    clear_stim();
    vde_en = 1'b0;
    emp_out = 1'b1;
    b_rd = rd_obs; b_un = un_obs;
    exp_aon.push_back(0);
    set_pos(3, 1990);
    run_to(0, 2);
    emp_out = 1'b0;
    set_pos(3, 1990);
    run_to(3, 1999);
    emp_out = 1'b1; emp_in = 1'b0; emp_lo = 0; emp_hi = 0;
    exp_aon.push_back(1);
    run_to(0, 2);
    emp_lo = 1; emp_hi = 0;
    exp_aon.push_back(1);
    set_pos(3, 1990);
    run_to(0, 2);
    exp_aon.push_back(0);
    set_pos(3, 1990);
    run_to(0, 2);
    end_scenario("s6_audio_on", b_rd, 0, b_un, 0);

    // S6b: vde raised during burst 2 -> abort, burst_cnt holds 1.
    do_reset();
    clear_stim();
    aleft_mode = 1;
    vde_pulse = 1575;
    b_rd = rd_obs; b_un = un_obs;
    push_reads(1, 1531, 1562);
    push_reads(1, 1567, 1575);
    exp_bc.push_back(1);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s6_vde_abort", b_rd, 41, b_un, 0);

    // S7: reset mid-burst drops rd_en at once; no reads until vde returns.
    do_reset();
    clear_stim();
    aleft_mode = 1;
    rst_lo = 1580; rst_hi = 1581;
    b_rd = rd_obs; b_un = un_obs;
    push_reads(1, 1531, 1562);
    push_reads(1, 1567, 1580);
    exp_bc.push_back(0);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s7_reset_mid", b_rd, 46, b_un, 0);

    // S8: vde and hcnt==START_H together -> abort wins, no burst.
    do_reset();
    clear_stim();
    vde_pulse = 1530;
    b_rd = rd_obs; b_un = un_obs;
    exp_bc.push_back(0);
    set_pos(1, 1270);
    run_to(1, 1999);
    end_scenario("s8_collision", b_rd, 0, b_un, 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
